// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-retirement store commit buffer: store packet,
// access size, FSM state encoding and default buffer depth.
package store_commit_buffer_pkg;

    localparam int XLEN       = 32;
    localparam int N_WAY      = 3;
    localparam int N_WR_PORTS = 2;
    localparam int N_SCB      = 4;
    localparam int SQ_IDX_W   = 3;

    typedef enum logic [1:0] {
        BYTE = 2'h0,
        HALF = 2'h1,
        WORD = 2'h2
    } MEM_SIZE;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     address;
        logic [XLEN-1:0]     data;
        MEM_SIZE             size;
        logic [SQ_IDX_W-1:0] store_pos;
    } STORE_PACKET_RET;

    typedef logic [1:0] SCB_STATE;
    localparam SCB_STATE SCB_IDLE = 2'd0;
    localparam SCB_STATE SCB_REQ  = 2'd1;
    localparam SCB_STATE SCB_WAIT = 2'd2;

    // Completion back to the store queue carries only the slot; address/data stay zero.
    function automatic STORE_PACKET_RET make_completion(input logic [SQ_IDX_W-1:0] pos);
        STORE_PACKET_RET p;
        p           = '0;
        p.valid     = 1'b1;
        p.store_pos = pos;
        return p;
    endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Store-queue and D-cache facing signals of the store commit buffer.
// slave = the buffer itself, master = its environment.
interface store_commit_buffer_if #(
    parameter int DEPTH = store_commit_buffer_pkg::N_SCB
);
    localparam int PTR_W = $clog2(DEPTH);

    store_commit_buffer_pkg::STORE_PACKET_RET st_ret_in [store_commit_buffer_pkg::N_WAY];
    logic [PTR_W:0]                           buf_free;
    logic                                     dc_req_valid;
    logic [store_commit_buffer_pkg::XLEN-1:0] dc_req_addr;
    logic [store_commit_buffer_pkg::XLEN-1:0] dc_req_data;
    store_commit_buffer_pkg::MEM_SIZE         dc_req_size;
    logic                                     dc_req_ready;
    logic                                     dc_done;
    store_commit_buffer_pkg::STORE_PACKET_RET sq_done_out [store_commit_buffer_pkg::N_WR_PORTS];
    logic                                     busy;

    modport master (
        output st_ret_in, dc_req_ready, dc_done,
        input  buf_free, dc_req_valid, dc_req_addr, dc_req_data, dc_req_size,
               sq_done_out, busy
    );

    modport slave (
        input  st_ret_in, dc_req_ready, dc_done,
        output buf_free, dc_req_valid, dc_req_addr, dc_req_data, dc_req_size,
               sq_done_out, busy
    );

endinterface

// File: rtl/store_commit_buffer_scb_fifo.sv
// N_WAY-write / 1-read circular FIFO of retired stores. Valid lanes are
// compacted into consecutive slots at the tail; lanes beyond free space drop.
module store_commit_buffer_scb_fifo
    import store_commit_buffer_pkg::*;
#(
    parameter int  DEPTH = N_SCB,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  STORE_PACKET_RET push_lanes [N_WAY],
    input  logic            pop,
    output STORE_PACKET_RET head_entry,
    output logic [PTR_W:0]  count,
    output logic [PTR_W:0]  n_push
);

    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    STORE_PACKET_RET  mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   free_slots;
    logic [PTR_W:0]   n_valid;
    logic [N_WAY-1:0] lane_we;
    logic [PTR_W-1:0] lane_off [N_WAY];

    // Free space is taken from the registered count; a same-cycle pop gives no credit.
    assign free_slots = (PTR_W+1)'(DEPTH) - count;
    assign head_entry = mem[head_ptr];

    // NOTE: every output gets a default before the loop so no latch is inferred;
    // n_push/n_valid are running sums, so blocking updates are intended here.
    always_comb begin
        n_push  = '0;
        n_valid = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_we[i]  = 1'b0;
            lane_off[i] = '0;
            if (push_lanes[i].valid) begin
                n_valid = n_valid + CNT_ONE;
                if (n_push < free_slots) begin
                    lane_we[i]  = 1'b1;
                    lane_off[i] = n_push[PTR_W-1:0];
                    n_push      = n_push + CNT_ONE;
                end
            end
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale slots are never seen.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++) begin
            if (lane_we[i]) begin
                mem[tail_ptr + lane_off[i]] <= push_lanes[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            tail_ptr <= tail_ptr + n_push[PTR_W-1:0];
            if (pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            count <= count + n_push - (PTR_W+1)'(pop);
        end
    end

    overflow_drop: assert property (@(posedge clock) disable iff (reset) n_valid <= free_slots);
    pop_when_empty: assert property (@(posedge clock) disable iff (reset) pop |-> count != '0);

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer top: FIFO of committed stores, in-order D-cache write FSM
// and one-cycle completion register. Optional STORE_BUF_BYPASS_EN: same-cycle issue from lane 0.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH = N_SCB
) (
    input logic                  clock,
    input logic                  reset,
    store_commit_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

    SCB_STATE        state;
    SCB_STATE        state_next;
    STORE_PACKET_RET head_entry;
    STORE_PACKET_RET done_reg;
    logic [PTR_W:0]  count;
    logic [PTR_W:0]  n_push;
    logic            pop;
    logic            bypass_req;

    store_commit_buffer_scb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_lanes (bus.st_ret_in),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
        .n_push     (n_push)
    );

    // dc_done is only meaningful for the write we are waiting on.
    assign pop = (state == SCB_WAIT) && bus.dc_done;

`ifdef STORE_BUF_BYPASS_EN
    assign bypass_req = (state == SCB_IDLE) && (count == '0) && bus.st_ret_in[0].valid;
`else
    assign bypass_req = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            SCB_IDLE: begin
                if (bypass_req && bus.dc_req_ready) begin
                    state_next = SCB_WAIT;
                end else if ((count != '0) || (n_push != '0)) begin
                    state_next = SCB_REQ;
                end
            end
            SCB_REQ: begin
                if (bus.dc_req_ready) begin
                    state_next = SCB_WAIT;
                end
            end
            SCB_WAIT: begin
                if (bus.dc_done) begin
                    state_next = ((count > CNT_ONE) || (n_push != '0)) ? SCB_REQ : SCB_IDLE;
                end
            end
            default: state_next = SCB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SCB_IDLE;
            done_reg <= '0;
        end else begin
            state    <= state_next;
            done_reg <= pop ? make_completion(head_entry.store_pos) : '0;
        end
    end

    always_comb begin
        bus.dc_req_valid = 1'b0;
        bus.dc_req_addr  = '0;
        bus.dc_req_data  = '0;
        bus.dc_req_size  = BYTE;
        if (state == SCB_REQ) begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_addr  = head_entry.address;
            bus.dc_req_data  = head_entry.data;
            bus.dc_req_size  = head_entry.size;
        end else if (bypass_req) begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_addr  = bus.st_ret_in[0].address;
            bus.dc_req_data  = bus.st_ret_in[0].data;
            bus.dc_req_size  = bus.st_ret_in[0].size;
        end
    end

    always_comb begin
        for (int i = 0; i < N_WR_PORTS; i++) begin
            bus.sq_done_out[i] = '0;
        end
        bus.sq_done_out[0] = done_reg;
    end

    assign bus.buf_free = (PTR_W+1)'(DEPTH) - count;
    assign bus.busy     = (count != '0) || (state != SCB_IDLE);

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer (default build) with a queue-based
// reference model checked every cycle plus hand-computed spot checks.
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    localparam int DEPTH = N_SCB;

    logic clock;
    logic reset;

    store_commit_buffer_if bus ();

    store_commit_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered queue of buffered stores, whether the head
    // write has been accepted by the cache, and the pending completion.
    STORE_PACKET_RET     m_q [$];
    logic                m_acc      = 1'b0;
    logic                m_done     = 1'b0;
    logic [SQ_IDX_W-1:0] m_done_pos = '0;
    int                  m_free;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_acc      = 1'b0;
            m_done     = 1'b0;
            m_done_pos = '0;
        end else begin
            m_free = DEPTH - m_q.size();
            m_done = 1'b0;
            if (m_acc && bus.dc_done) begin
                m_done     = 1'b1;
                m_done_pos = m_q[0].store_pos;
                void'(m_q.pop_front());
                m_acc = 1'b0;
            end else if (!m_acc && m_q.size() > 0 && bus.dc_req_ready) begin
                m_acc = 1'b1;
            end
            for (int i = 0; i < N_WAY; i++) begin
                if (bus.st_ret_in[i].valid && m_free > 0) begin
                    m_q.push_back(bus.st_ret_in[i]);
                    m_free--;
                end
            end
        end
    end

    logic                cmp_en = 1'b0;
    logic                exp_valid;
    int                  done_count = 0;
    logic [SQ_IDX_W-1:0] done_log [$];

    always @(negedge clock) begin
        if (cmp_en) begin
            exp_valid = (m_q.size() > 0) && !m_acc;
            check("buf_free", 64'(bus.buf_free), 64'(DEPTH - m_q.size()));
            check("req_valid", 64'(bus.dc_req_valid), 64'(exp_valid));
            check("req_addr", 64'(bus.dc_req_addr), 64'(exp_valid ? m_q[0].address : 32'h0));
            check("req_data", 64'(bus.dc_req_data), 64'(exp_valid ? m_q[0].data : 32'h0));
            check("req_size", 64'(bus.dc_req_size), 64'(exp_valid ? m_q[0].size : BYTE));
            check("busy", 64'(bus.busy), 64'(m_q.size() > 0));
            check("done_valid", 64'(bus.sq_done_out[0].valid), 64'(m_done));
            check("done_pos", 64'(bus.sq_done_out[0].store_pos), 64'(m_done ? m_done_pos : '0));
            check("done_addr_data", {bus.sq_done_out[0].address, bus.sq_done_out[0].data}, 64'h0);
            check("done_port1_valid", 64'(bus.sq_done_out[1].valid), 64'h0);
            if (bus.sq_done_out[0].valid) begin
                done_count++;
                done_log.push_back(bus.sq_done_out[0].store_pos);
            end
        end
    end

    function automatic STORE_PACKET_RET mk(input logic [31:0] a, input logic [31:0] d,
                                           input MEM_SIZE s, input logic [SQ_IDX_W-1:0] pos);
        STORE_PACKET_RET p;
        p.valid     = 1'b1;
        p.address   = a;
        p.data      = d;
        p.size      = s;
        p.store_pos = pos;
        return p;
    endfunction

    task automatic clear_lanes();
        for (int i = 0; i < N_WAY; i++) bus.st_ret_in[i] = '0;
    endtask

    task automatic push1(input STORE_PACKET_RET p);
        clear_lanes();
        bus.st_ret_in[0] = p;
        @(negedge clock);
        clear_lanes();
    endtask

    // Accept the next request (bounded wait), then signal dc_done after d idle cycles.
    task automatic serve_one(input int d);
        int k = 0;
        bus.dc_req_ready = 1'b1;
        while (!bus.dc_req_valid && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("req_seen", 64'(bus.dc_req_valid), 64'h1);
        @(negedge clock);
        repeat (d) @(negedge clock);
        bus.dc_done = 1'b1;
        @(negedge clock);
        bus.dc_done = 1'b0;
    endtask

    int saved_count;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus.dc_req_ready = 1'b0;
        bus.dc_done      = 1'b0;
        clear_lanes();
        @(posedge clock);
        cmp_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 1: idle after reset
        repeat (10) @(negedge clock);
        check("t1_buf_free", 64'(bus.buf_free), 64'd4);
        check("t1_req_valid", 64'(bus.dc_req_valid), 64'd0);
        check("t1_busy", 64'(bus.busy), 64'd0);

        // 2: single word store, request the cycle after enqueue, done two cycles after accept
        bus.dc_req_ready = 1'b1;
        push1(mk(32'h100, 32'hDEADBEEF, WORD, 3'd3));
        check("t2_req_next_cycle", 64'(bus.dc_req_valid), 64'd1);
        check("t2_req_addr", 64'(bus.dc_req_addr), 64'h100);
        check("t2_req_data", 64'(bus.dc_req_data), 64'hDEADBEEF);
        @(negedge clock);
        check("t2_wait_no_req", 64'(bus.dc_req_valid), 64'd0);
        @(negedge clock);
        bus.dc_done = 1'b1;
        @(negedge clock);
        bus.dc_done = 1'b0;
        check("t2_done_valid", 64'(bus.sq_done_out[0].valid), 64'd1);
        check("t2_done_pos", 64'(bus.sq_done_out[0].store_pos), 64'd3);
        @(negedge clock);
        check("t2_done_once", 64'(done_count), 64'd1);
        check("t2_buf_free", 64'(bus.buf_free), 64'd4);

        // 3: sparse lanes compacted, issued and completed in program order
        done_log.delete();
        bus.dc_req_ready = 1'b0;
        bus.st_ret_in[0] = mk(32'h200, 32'h11111111, HALF, 3'd1);
        bus.st_ret_in[1] = mk(32'h999, 32'h00000BAD, WORD, 3'd7);
        bus.st_ret_in[1].valid = 1'b0;
        bus.st_ret_in[2] = mk(32'h204, 32'h22222222, BYTE, 3'd2);
        @(negedge clock);
        clear_lanes();
        check("t3_buf_free", 64'(bus.buf_free), 64'd2);
        check("t3_first_addr", 64'(bus.dc_req_addr), 64'h200);
        serve_one(1);
        check("t3_second_addr", 64'(bus.dc_req_addr), 64'h204);
        serve_one(1);
        repeat (2) @(negedge clock);
        check("t3_done_n", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            check("t3_order0", 64'(done_log[0]), 64'd1);
            check("t3_order1", 64'(done_log[1]), 64'd2);
        end

        // 4: fill to full while the cache stalls, stray dc_done ignored, then drain with wrap
        done_log.delete();
        bus.dc_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            bus.st_ret_in[i] = mk(32'h300 + 32'(4*i), 32'hA0 + 32'(i), WORD, SQ_IDX_W'(4 + i));
        @(negedge clock);
        clear_lanes();
        bus.st_ret_in[0] = mk(32'h30C, 32'hA3, WORD, 3'd7);
        @(negedge clock);
        clear_lanes();
        check("t4_full", 64'(bus.buf_free), 64'd0);
        check("t4_addr_start", 64'(bus.dc_req_addr), 64'h300);
        saved_count = done_count;
        bus.dc_done = 1'b1;
        @(negedge clock);
        bus.dc_done = 1'b0;
        repeat (18) @(negedge clock);
        check("t4_addr_stable", 64'(bus.dc_req_addr), 64'h300);
        check("t4_data_stable", 64'(bus.dc_req_data), 64'hA0);
        check("t4_still_full", 64'(bus.buf_free), 64'd0);
        check("t4_stray_done", 64'(done_count), 64'(saved_count));
        repeat (4) serve_one(0);
        repeat (2) @(negedge clock);
        check("t4_drained", 64'(bus.buf_free), 64'd4);
        check("t4_done_n", 64'(done_log.size()), 64'd4);
        if (done_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("t4_order", 64'(done_log[i]), 64'(4 + i));
        end

        // 5: enqueue in the dc_done cycle with one entry buffered
        done_log.delete();
        bus.dc_req_ready = 1'b1;
        push1(mk(32'h400, 32'h55, WORD, 3'd0));
        @(negedge clock);
        bus.dc_done      = 1'b1;
        bus.st_ret_in[0] = mk(32'h404, 32'h66, HALF, 3'd5);
        @(negedge clock);
        bus.dc_done = 1'b0;
        clear_lanes();
        check("t5_count_kept", 64'(bus.buf_free), 64'd3);
        check("t5_next_req", 64'(bus.dc_req_valid), 64'd1);
        check("t5_next_addr", 64'(bus.dc_req_addr), 64'h404);
        check("t5_done_valid", 64'(bus.sq_done_out[0].valid), 64'd1);
        serve_one(0);
        repeat (2) @(negedge clock);
        check("t5_done_n", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) check("t5_order1", 64'(done_log[1]), 64'd5);

        // 6: reset while waiting for dc_done abandons the write without completion
        push1(mk(32'h500, 32'h77, WORD, 3'd6));
        @(negedge clock);
        check("t6_in_wait", 64'(bus.dc_req_valid), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd1);
        saved_count = done_count;
        reset       = 1'b1;
        bus.dc_done = 1'b1;
        @(negedge clock);
        reset       = 1'b0;
        bus.dc_done = 1'b0;
        check("t6_empty", 64'(bus.buf_free), 64'd4);
        check("t6_no_req", 64'(bus.dc_req_valid), 64'd0);
        check("t6_idle", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clock);
        check("t6_no_completion", 64'(done_count), 64'(saved_count));
        bus.dc_req_ready = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
